// File: rtl/ex_div_ctrl_if.sv
// EX <-> divide sequencer handshake: request operands, flush kill, busy stall
// and the one-cycle result strobe.
interface ex_div_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic [1:0]      req_op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            busy;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;

    modport master (
        output req_valid, req_op, src_a, src_b, flush,
        input  busy, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, src_a, src_b, flush,
        output busy, resp_valid, resp_data
    );
endinterface

// File: rtl/ex_div_ctrl.sv
// Radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU beside EX.
// Optional feature macro: DIV_EARLY_OUT_EN (skip CALC for trivially resolved ops).
module ex_div_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          resetn,
    ex_div_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_a;
    logic            r_sel_rem;
    logic            r_qneg;
    logic            r_rneg;
    logic            r_bzero;
    logic            r_ovf;
    logic            r_busy;
    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_data;

    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_b_zero;
    logic            w_ovf;
    logic [XLEN:0]   w_sh;
    logic            w_ge;
    logic [XLEN:0]   w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;

    assign w_signed = ~bus.req_op[0];
    assign w_a_neg  = w_signed & bus.src_a[XLEN-1];
    assign w_b_neg  = w_signed & bus.src_b[XLEN-1];
    assign w_a_abs  = w_a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
    assign w_b_abs  = w_b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
    assign w_b_zero = (bus.src_b == '0);
    assign w_ovf    = w_signed & (bus.src_a == MIN_NEG) & (bus.src_b == '1);

    // A set top bit would mean the shifted remainder already exceeds any divisor.
    assign w_sh      = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
    assign w_ge      = r_rem[XLEN] | (w_sh >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? (w_sh - {1'b0, r_div}) : w_sh;
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

    // Sign fix-up followed by the RISC-V defined overrides.
    function automatic logic [XLEN-1:0] f_result(
        input logic            sel_rem,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem,
        input logic [XLEN-1:0] a_raw,
        input logic            qneg,
        input logic            rneg,
        input logic            bzero,
        input logic            ovf
    );
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        q = qneg ? (~quo + 1'b1) : quo;
        r = rneg ? (~rem + 1'b1) : rem;
        if (bzero) begin
            q = '1;
            r = a_raw;
        end else if (ovf) begin
            q = a_raw;
            r = '0;
        end
        return sel_rem ? r : q;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_div        <= '0;
            r_a          <= '0;
            r_sel_rem    <= 1'b0;
            r_qneg       <= 1'b0;
            r_rneg       <= 1'b0;
            r_bzero      <= 1'b0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && !bus.flush) begin
                        r_sel_rem <= bus.req_op[1];
                        r_qneg    <= w_a_neg ^ w_b_neg;
                        r_rneg    <= w_a_neg;
                        r_bzero   <= w_b_zero;
                        r_ovf     <= w_ovf;
                        r_a       <= bus.src_a;
                        r_quo     <= w_a_abs;
                        r_div     <= w_b_abs;
                        r_rem     <= '0;
                        r_busy    <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        if (w_b_zero || w_ovf || (w_a_abs < w_b_abs)) begin
                            // q=0, r=src_a unless an override applies
                            r_resp_data  <= f_result(bus.req_op[1], '0, w_a_abs, bus.src_a,
                                                     w_a_neg ^ w_b_neg, w_a_neg, w_b_zero, w_ovf);
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_cnt   <= CNT_W'(XLEN);
                            r_state <= S_CALC;
                        end
`else
                        r_cnt   <= CNT_W'(XLEN);
                        r_state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_resp_data  <= f_result(r_sel_rem, w_quo_nxt, w_rem_nxt[XLEN-1:0], r_a,
                                                     r_qneg, r_rneg, r_bzero, r_ovf);
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_resp_valid <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    // A flush landing in DONE must suppress the strobe in that same cycle.
    assign bus.resp_valid = r_resp_valid & ~bus.flush;
    assign bus.resp_data  = r_resp_data;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Randomized + directed bench for ex_div_ctrl against an arithmetic reference model.
module tb_ex_div_ctrl;
    localparam int XLEN = 32;
    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ex_div_ctrl_if #(.XLEN(XLEN)) bus ();

    ex_div_ctrl #(.XLEN(XLEN), .CNT_W(6)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        ua = longint'(a);
        ub = longint'(b);
        return op[1] ? 32'(ua % ub) : 32'(ua / ub);
    endfunction

    // Cycles from the accept edge to the response strobe.
    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        longint ma, mb;
        if (b == 32'd0) return 1;
        if (!op[0]) begin
            ma = longint'($signed(a));
            mb = longint'($signed(b));
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end else begin
            ma = longint'(a);
            mb = longint'(b);
        end
        if (ma < mb) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
`else
        return (op == 2'd0 && a == b && b == 32'd1) ? XLEN + 1 : XLEN + 1;
`endif
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.src_a     = a;
        bus.src_b     = b;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        int lat, n, busy_bad;
        bit seen;
        logic [31:0] exp;
        exp      = ref_div(op, a, b);
        lat      = ref_lat(op, a, b);
        seen     = 1'b0;
        n        = 0;
        busy_bad = 0;
        issue(op, a, b);
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.resp_valid === 1'b1) seen = 1'b1;
            // junk request while busy must be ignored
            if (poke && lat > 5 && n == 3) begin
                bus.req_valid = 1'b1;
                bus.req_op    = 2'($urandom_range(0, 3));
                bus.src_a     = $urandom;
                bus.src_b     = $urandom;
            end
            if (n == 4) bus.req_valid = 1'b0;
        end
        chk("latency", n, lat);
        chk("busy_during_op", busy_bad, 0);
        chk("resp_data", bus.resp_data, exp);
        @(negedge clk);
        chk("busy_after", bus.busy, 1'b0);
        chk("rv_after", bus.resp_valid, 1'b0);
        chk("data_hold", bus.resp_data, exp);
    endtask

    task automatic run_flush(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int kill_at);
        int k, rv;
        k  = ref_lat(op, a, b);
        if (kill_at < k) k = kill_at;
        rv = 0;
        issue(op, a, b);
        for (int n = 1; n <= k; n++) begin
            @(negedge clk);
            if (n == k) begin
                bus.flush = 1'b1;
                #1 chk("flush_rv", bus.resp_valid, 1'b0);
            end
        end
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", bus.busy, 1'b0);
        repeat (40) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) rv++;
        end
        chk("flush_noresp", rv, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.flush     = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rv", bus.resp_valid, 1'b0);
        chk("rst_data", bus.resp_data, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        run_op(OP_DIV, 32'd100, 32'd7, 1'b0);
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(OP_DIVU, 32'd5, 32'd0, 1'b0);
        run_op(OP_REMU, 32'd5, 32'd0, 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
        run_op(OP_REM, 32'd3, 32'hFFFF_FFF6, 1'b0);

        run_flush(OP_DIV, 32'd1000, 32'd7, 10);
        run_op(OP_DIVU, 32'd9, 32'd3, 1'b0);
        run_flush(OP_DIV, 32'd1000, 32'd3, XLEN + 1);
        run_op(OP_REMU, 32'd1000, 32'd7, 1'b0);

        // async reset in the middle of an operation
        issue(OP_DIVU, 32'd12345, 32'd17);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_rv", bus.resp_valid, 1'b0);
        chk("midrst_data", bus.resp_data, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op(OP_DIVU, 32'd12345, 32'd17, 1'b0);

        for (int i = 0; i < 60; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
